// File: rtl/pwm_comparador_pkg.sv
// -----------------------------------------------------------------------------
// pwm_pkg
// Shared types and constants for the pwm_comparador PWM output stage.
//   PWM_WIDTH    : default width of carrier and reference words
//   DEAD_CNT_W   : width of the dead-time counter (dead time up to 255 clk)
//   duty_t       : reference/carrier word type
//   is_full_duty : true when a duty word requests forced 100 % duty
// -----------------------------------------------------------------------------
package pwm_pkg;

  localparam int PWM_WIDTH  = 10;
  localparam int DEAD_CNT_W = 8;

  typedef logic [PWM_WIDTH-1:0] duty_t;

  // All-ones reference means "always on", even when the carrier reaches its
  // own maximum, where a plain greater-than compare would give one low cycle.
  function automatic logic is_full_duty(input duty_t duty);
    return &duty;
  endfunction

endpackage : pwm_pkg

// File: rtl/pwm_comparador_if.sv
// -----------------------------------------------------------------------------
// pwm_comparador_if
// Carrier/reference inputs and PWM outputs of the comparator stage.
//   frec_conm  : carrier count (unsigned), driven by the carrier counter
//   corri_ref  : reference/duty word (unsigned)
//   out_pwm    : registered PWM output
//   out_pwm_n  : complementary output, only with PWM_COMPARADOR_DEADTIME_EN
// Modports: master drives carrier/reference, slave (the comparator) drives
// the PWM outputs.
// -----------------------------------------------------------------------------
interface pwm_comparador_if
  import pwm_pkg::*;
#(
  parameter int WIDTH = PWM_WIDTH
) ();

  logic [WIDTH-1:0] frec_conm;
  logic [WIDTH-1:0] corri_ref;
  logic             out_pwm;
`ifdef PWM_COMPARADOR_DEADTIME_EN
  logic             out_pwm_n;

  modport master (output frec_conm, output corri_ref, input  out_pwm, input  out_pwm_n);
  modport slave  (input  frec_conm, input  corri_ref, output out_pwm, output out_pwm_n);
`else
  modport master (output frec_conm, output corri_ref, input  out_pwm);
  modport slave  (input  frec_conm, input  corri_ref, output out_pwm);
`endif

endinterface : pwm_comparador_if

// File: rtl/pwm_comparador_deadtime.sv
// -----------------------------------------------------------------------------
// pwm_deadtime
// Dead-time inserter for the complementary PWM pair. Built only when
// PWM_COMPARADOR_DEADTIME_EN is defined.
//   clk, rst_n : system clock, asynchronous active-low reset
//   i_raw      : unregistered compare result
//   o_pwm      : high-side drive, 0 during dead time
//   o_pwm_n    : low-side drive,  0 during dead time
// Every change of i_raw blanks both outputs for DEAD_CYCLES clocks; a change
// during blanking restarts the count, so short raw pulses are swallowed.
// -----------------------------------------------------------------------------
`ifdef PWM_COMPARADOR_DEADTIME_EN
module pwm_deadtime
  import pwm_pkg::*;
#(
  parameter int DEAD_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_raw,
  output logic o_pwm,
  output logic o_pwm_n
);

  // The edge cycle itself is the first blanked cycle, so the counter holds
  // the number of blanked cycles still to come after it.
  localparam logic [DEAD_CNT_W-1:0] DEAD_LOAD = DEAD_CNT_W'(DEAD_CYCLES - 1);

  logic                  r_raw_q;
  logic [DEAD_CNT_W-1:0] r_cnt;
  logic                  r_pwm;
  logic                  r_pwm_n;
  logic                  w_edge;

  assign w_edge = i_raw ^ r_raw_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // Preloaded so the first driven state also waits out a full dead time.
      r_raw_q <= 1'b0;
      r_cnt   <= DEAD_LOAD;
      r_pwm   <= 1'b0;
      r_pwm_n <= 1'b0;
    end else begin
      r_raw_q <= i_raw;
      if (w_edge) begin
        r_cnt   <= DEAD_LOAD;
        r_pwm   <= 1'b0;
        r_pwm_n <= 1'b0;
      end else if (r_cnt != '0) begin
        r_cnt   <= r_cnt - DEAD_CNT_W'(1);
        r_pwm   <= 1'b0;
        r_pwm_n <= 1'b0;
      end else begin
        r_pwm   <= i_raw;
        r_pwm_n <= ~i_raw;
      end
    end
  end

  assign o_pwm   = r_pwm;
  assign o_pwm_n = r_pwm_n;

endmodule : pwm_deadtime
`endif

// File: rtl/pwm_comparador.sv
// -----------------------------------------------------------------------------
// pwm_comparador
// PWM output stage: compares the free-running carrier against a
// shadow-buffered reference and drives a registered PWM bit.
//   clk, rst_n : system clock, asynchronous active-low reset
//   bus        : pwm_comparador_if.slave (frec_conm, corri_ref in; out_pwm out)
// Parameters:
//   WIDTH        : carrier/reference width
//   LOAD_AT_WRAP : 1 = shadow loads only on carrier wrap, 0 = every cycle
//   DEAD_CYCLES  : dead time in clk cycles (1..255), with the macro only
// Optional feature macro PWM_COMPARADOR_DEADTIME_EN adds out_pwm_n with
// dead-time insertion (pwm_deadtime); otherwise out_pwm is raw delayed 1 clk.
// -----------------------------------------------------------------------------
module pwm_comparador
  import pwm_pkg::*;
#(
  parameter int WIDTH        = PWM_WIDTH,
`ifdef PWM_COMPARADOR_DEADTIME_EN
  parameter int DEAD_CYCLES  = 4,
`endif
  parameter bit LOAD_AT_WRAP = 1'b1
) (
  input logic              clk,
  input logic              rst_n,
  pwm_comparador_if.slave  bus
);

  logic [WIDTH-1:0] r_prev_carrier;
  logic [WIDTH-1:0] r_ref_shadow;
  logic             r_first;

  logic             w_wrap;
  logic             w_load;
  logic [WIDTH-1:0] w_ref_eff;
  logic             w_full;
  logic             w_raw;

  // Any backwards step of the carrier counts as a wrap, so non-monotonic
  // jumps also reload the shadow.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so
    // no path leaves a value held, which would infer a latch.
    w_wrap    = 1'b0;
    w_load    = 1'b0;
    w_ref_eff = r_ref_shadow;

    w_wrap = (bus.frec_conm < r_prev_carrier);
    w_load = r_first || !LOAD_AT_WRAP || w_wrap;
    // The compare sees the value being loaded this cycle, not the old shadow.
    if (w_load) begin
      w_ref_eff = bus.corri_ref;
    end
  end

  if (WIDTH == PWM_WIDTH) begin : g_full_pkg
    assign w_full = is_full_duty(w_ref_eff);
  end else begin : g_full_generic
    assign w_full = &w_ref_eff;
  end

  // A zero reference falls out of the strict compare: 0 > carrier is never true.
  assign w_raw = w_full | (w_ref_eff > bus.frec_conm);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prev_carrier <= '0;
      r_ref_shadow   <= '0;
      r_first        <= 1'b1;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values regardless of statement order.
      r_prev_carrier <= bus.frec_conm;
      r_first        <= 1'b0;
      if (w_load) begin
        r_ref_shadow <= bus.corri_ref;
      end
    end
  end

`ifdef PWM_COMPARADOR_DEADTIME_EN
  pwm_deadtime #(
    .DEAD_CYCLES (DEAD_CYCLES)
  ) u_deadtime (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_raw   (w_raw),
    .o_pwm   (bus.out_pwm),
    .o_pwm_n (bus.out_pwm_n)
  );
`else
  logic r_pwm;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pwm <= 1'b0;
    end else begin
      r_pwm <= w_raw;
    end
  end

  assign bus.out_pwm = r_pwm;
`endif

endmodule : pwm_comparador

// File: tb/tb_pwm_comparador.sv
// -----------------------------------------------------------------------------
// tb_pwm_comparador
// Two comparator instances: dut0 reloads the reference every cycle,
// dut1 reloads only on carrier wrap. Stimulus pushes hand-derived expected
// outputs into per-instance queues; monitors pop and compare one clock later.
// With PWM_COMPARADOR_DEADTIME_EN the dead-time sequence is exercised instead.
// -----------------------------------------------------------------------------
module tb_pwm_comparador;
  import pwm_pkg::*;

  logic clk = 1'b0;
  logic rst_n;

  int n_checks = 0;
  int n_errors = 0;

  // Expected {out_pwm_n, out_pwm} and a label, one entry per driven cycle.
  logic [1:0] q0_exp[$];
  string      q0_name[$];
  logic [1:0] q1_exp[$];
  string      q1_name[$];

  pwm_comparador_if bus0 ();
  pwm_comparador_if bus1 ();

  pwm_comparador #(.LOAD_AT_WRAP(1'b0)) dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus0.slave)
  );

  pwm_comparador #(.LOAD_AT_WRAP(1'b1)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic set0(input int c, input int r, input logic ep, input logic en, input string name);
    bus0.frec_conm = duty_t'(c);
    bus0.corri_ref = duty_t'(r);
    q0_exp.push_back({en, ep});
    q0_name.push_back($sformatf("d0_%s_c%0d_r%0d", name, c, r));
  endtask

  task automatic set1(input int c, input int r, input logic ep, input logic en, input string name);
    bus1.frec_conm = duty_t'(c);
    bus1.corri_ref = duty_t'(r);
    q1_exp.push_back({en, ep});
    q1_name.push_back($sformatf("d1_%s_c%0d_r%0d", name, c, r));
  endtask

  task automatic drain();
    for (int i = 0; i < 10 && (q0_exp.size() != 0 || q1_exp.size() != 0); i++) @(posedge clk);
    #2;
    check("drain_timeout", q0_exp.size() + q1_exp.size(), 0);
  endtask

  initial begin : mon0
    logic [1:0] e;
    string      nm;
    forever begin
      @(posedge clk);
      if (q0_exp.size() != 0) begin
        e  = q0_exp.pop_front();
        nm = q0_name.pop_front();
        #1;
        check(nm, 32'(bus0.out_pwm), 32'(e[0]));
`ifdef PWM_COMPARADOR_DEADTIME_EN
        check({nm, "_n"}, 32'(bus0.out_pwm_n), 32'(e[1]));
        check({nm, "_overlap"}, 32'(bus0.out_pwm & bus0.out_pwm_n), 0);
`endif
      end
    end
  end

  initial begin : mon1
    logic [1:0] e;
    string      nm;
    forever begin
      @(posedge clk);
      if (q1_exp.size() != 0) begin
        e  = q1_exp.pop_front();
        nm = q1_name.pop_front();
        #1;
        check(nm, 32'(bus1.out_pwm), 32'(e[0]));
`ifdef PWM_COMPARADOR_DEADTIME_EN
        check({nm, "_n"}, 32'(bus1.out_pwm_n), 32'(e[1]));
        check({nm, "_overlap"}, 32'(bus1.out_pwm & bus1.out_pwm_n), 0);
`endif
      end
    end
  end

`ifndef PWM_COMPARADOR_DEADTIME_EN
  typedef struct {
    int   c;
    int   r;
    logic e;
  } vec_t;

  int   sweep_ref[4] = '{0, 102, 512, 1023};
  logic sweep_lo[4]  = '{1'b0, 1'b1, 1'b1, 1'b1};  // expected at carrier 0
  logic sweep_hi[4]  = '{1'b0, 1'b0, 1'b0, 1'b1};  // expected at carrier 1023
  vec_t edge_tab[6]  = '{
    '{409,  409,  1'b0},
    '{409,  410,  1'b1},
    '{409,  408,  1'b0},
    '{0,    0,    1'b0},
    '{1023, 1023, 1'b1},
    '{1023, 1022, 1'b0}
  };
`endif

  initial begin : stim
    rst_n          = 1'b0;
    bus0.frec_conm = '0;
    bus0.corri_ref = '0;
    bus1.frec_conm = '0;
    bus1.corri_ref = '0;

`ifndef PWM_COMPARADOR_DEADTIME_EN
    // Reset with full-duty reference: output must stay low until release.
    repeat (3) begin
      @(negedge clk);
      set0(0, 1023, 1'b0, 1'b0, "in_reset");
      set1(0, 1023, 1'b0, 1'b0, "in_reset");
    end
    @(negedge clk);
    rst_n = 1'b1;
    set0(0, 1023, 1'b1, 1'b0, "first_load");
    set1(0, 1023, 1'b1, 1'b0, "first_load");
    @(negedge clk);
    set0(0, 1023, 1'b1, 1'b0, "hold_full");
    set1(0, 1023, 1'b1, 1'b0, "hold_full");

    // Carrier alternating 0/1023, reference loaded every cycle (dut0).
    for (int i = 0; i < 4; i++) begin
      for (int k = 0; k < 2; k++) begin
        @(negedge clk);
        set0(0, sweep_ref[i], sweep_lo[i], 1'b0, "sweep");
        @(negedge clk);
        set0(1023, sweep_ref[i], sweep_hi[i], 1'b0, "sweep");
      end
    end

    // Equality and range boundaries (dut0).
    foreach (edge_tab[i]) begin
      @(negedge clk);
      set0(edge_tab[i].c, edge_tab[i].r, edge_tab[i].e, 1'b0, "edge");
    end

    // Shadow buffering on dut1. Shadow still holds 1023: change is ignored.
    @(negedge clk);
    set1(1023, 256, 1'b1, 1'b0, "between_wraps");
    // Period A: ref moves to 768 mid-period, high time stays 256.
    for (int c = 0; c < 1024; c++) begin
      @(negedge clk);
      set1(c, (c < 500) ? 256 : 768, (c < 256), 1'b0, "period_a");
    end
    // Period B: 768 loaded at wrap; later edits 100 then 300.
    for (int c = 0; c < 1024; c++) begin
      @(negedge clk);
      set1(c, (c < 600) ? 768 : ((c < 900) ? 100 : 300), (c < 768), 1'b0, "period_b");
    end
    // Period C: only the last value present at the wrap (300) is used.
    for (int c = 0; c <= 400; c++) begin
      @(negedge clk);
      set1(c, 300, (c < 300), 1'b0, "period_c");
    end

    // Async reset mid-period at carrier 100 with ref 512.
    @(negedge clk);
    set1(1023, 512, 1'b0, 1'b0, "pre_wrap_d");
    for (int c = 0; c <= 100; c++) begin
      @(negedge clk);
      set1(c, 512, 1'b1, 1'b0, "period_d");
    end
    drain();
    check("pre_reset_high", 32'(bus1.out_pwm), 1);
    rst_n = 1'b0;
    #1;
    check("async_reset_fall", 32'(bus1.out_pwm), 0);
    repeat (2) begin
      @(negedge clk);
      set1(101, 200, 1'b0, 1'b0, "in_reset_mid");
    end
    @(negedge clk);
    rst_n = 1'b1;
    set1(101, 200, 1'b1, 1'b0, "reload_after_reset");
    // No wrap follows, so the later change to 900 must be ignored.
    for (int c = 102; c <= 250; c++) begin
      @(negedge clk);
      set1(c, (c < 150) ? 200 : 900, (c < 200), 1'b0, "period_e");
    end
    drain();
`else
    // Dead time of 4 cycles, ref 512 ramp on both instances.
    repeat (3) begin
      @(negedge clk);
      set0(0, 512, 1'b0, 1'b0, "in_reset");
      set1(0, 512, 1'b0, 1'b0, "in_reset");
    end
    for (int p = 0; p < 2; p++) begin
      for (int c = 0; c < 1024; c++) begin
        @(negedge clk);
        if (p == 0 && c == 0) rst_n = 1'b1;
        set0(c, 512, (c >= 4 && c < 512), (c >= 516), "ramp");
        set1(c, 512, (c >= 4 && c < 512), (c >= 516), "ramp");
      end
    end
    // 2-cycle raw pulse on dut0 is swallowed.
    repeat (6) begin @(negedge clk); set0(0, 0, 1'b0, 1'b1, "steady_low"); end
    repeat (2) begin @(negedge clk); set0(0, 5, 1'b0, 1'b0, "short_pulse"); end
    repeat (4) begin @(negedge clk); set0(0, 0, 1'b0, 1'b0, "dead_after_pulse"); end
    repeat (3) begin @(negedge clk); set0(0, 0, 1'b0, 1'b1, "settled"); end
    drain();
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule : tb_pwm_comparador

// File: doc/pwm_comparador.md
Name: pwm_comparador

Overview:
- Digital PWM output stage. Compares a free-running carrier (switching-frequency sawtooth/triangle count) against a current-reference word and produces a registered PWM bit.
- Sits between the carrier counter and the gate-drive pins of the DigitalPWM design.
- Reference is shadow-buffered so duty changes never cause mid-period glitches.

Parameters:
- WIDTH, 10, bit width of carrier and reference.
- LOAD_AT_WRAP, 1, 1 = reference shadow loads only at carrier wrap; 0 = loads every cycle.
- DEAD_CYCLES, 4, dead-time length in clk cycles; used only with DEADTIME_EN; legal range 1..255.

Ports:
- clk  in  1  single system clock; all state is rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- frec_conm  in  WIDTH  carrier count, unsigned, sampled every clk.
- corri_ref  in  WIDTH  reference/duty word, unsigned.
- out_pwm  out  1  registered PWM output.
- out_pwm_n  out  1  complementary output; present only with DEADTIME_EN.

Behaviour:
- Reset (async assert, sync release):
  - out_pwm = 0, out_pwm_n = 0.
  - ref_shadow = 0, prev_carrier = 0, first_flag = 1.
- Wrap detect: wrap = (frec_conm < prev_carrier). prev_carrier <= frec_conm every cycle.
- Shadow load:
  - Loads corri_ref when first_flag is set (first active cycle after reset).
  - Otherwise loads when LOAD_AT_WRAP = 0, or when wrap = 1.
  - first_flag clears after the first active cycle.
- Shadow read timing: the load takes effect for the comparison in the same cycle it occurs. The compare reads the load mux output, not the old register.
- Compare, unsigned, full WIDTH:
  - raw = 1 if ref_eff > frec_conm.
  - raw = 1 unconditionally if ref_eff is all-ones (forced 100 % duty).
  - raw = 0 if ref_eff = 0 (0 % duty, for any carrier value).
- Output: out_pwm <= raw. Latency is exactly 1 clk from sampled inputs to out_pwm.
- Equality (ref_eff == carrier, not all-ones) gives 0.
- Carrier values are unconstrained; non-monotonic jumps count as wraps.
- A reference change between wraps (LOAD_AT_WRAP = 1) is ignored until the next wrap. Only the last value present at the wrap cycle is used.
- Reset mid-period: output goes low immediately. The first post-reset cycle loads the reference unconditionally.
- Inputs are assumed synchronous to clk. No internal synchronizers.

Optional Feature:
- Macro: PWM_COMPARADOR_DEADTIME_EN.
- Defined:
  - Adds out_pwm_n.
  - On every edge of raw, both outputs are held 0 for DEAD_CYCLES clk cycles, then the new state is driven: out_pwm = raw, out_pwm_n = ~raw.
  - A raw pulse shorter than DEAD_CYCLES is swallowed (both stay 0) and the counter restarts on each edge.
  - out_pwm and out_pwm_n are never 1 simultaneously.
  - Both outputs are 0 at reset; the dead counter is preloaded so the first state is driven after DEAD_CYCLES.
- Undefined: out_pwm_n absent; out_pwm = registered raw as above, 1-cycle latency.

Decomposition:
- Package pwm_pkg holds:
  - PWM_WIDTH = 10.
  - DEAD_CNT_W = 8.
  - typedef duty_t (logic [PWM_WIDTH-1:0]).
  - Function is_full_duty().
- Optional sub-module pwm_deadtime: raw in; out_pwm/out_pwm_n out; counter inside. Instantiated only under the macro.
- Comparator and shadow logic stay in the top.

Test Plan:
- Reset: hold rst_n = 0 with corri_ref = 10'h3FF, frec_conm = 0 -> out_pwm = 0 throughout; after release, out_pwm = 1 one cycle later.
- Sweep (LOAD_AT_WRAP = 0), carrier alternating 0/1023 each cycle:
  - ref 0 -> always 0.
  - ref 102 -> 1 at carrier 0, 0 at 1023.
  - ref 512 -> same pattern.
  - ref 1023 -> always 1.
  - Each with 1-cycle latency.
- Equality: carrier = 409, ref = 409 -> 0; ref = 410 -> 1; ref = 408 -> 0.
- Shadow (LOAD_AT_WRAP = 1), carrier 0..1023 ramp:
  - Change ref 256 -> 768 at carrier 500 -> high time stays 256 cycles this period.
  - Next period high for 768 cycles.
  - Only the last ref value before the wrap is used.
- Async reset mid-period at carrier 100, ref 512 -> out_pwm falls without a clock edge; after release, compare resumes with the newly loaded ref.
- PWM_COMPARADOR_DEADTIME_EN, DEAD_CYCLES = 4:
  - Ref 512 ramp -> 4 cycles of both-low at each transition; never both high.
  - A 2-cycle raw pulse is swallowed.
